// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arb
// Purpose  : Round-robin scheduler that time-shares one registered multiplier
//            among NREQ requesters. It accepts one valid/ready operand pair
//            at a time, waits MULT_LAT cycles for the product, and returns it
//            on a per-requester response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_arb #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MULT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*DW-1:0]   rsp_data,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [DW-1:0]     m_i0,
  output logic [DW-1:0]     m_i1,
  input  logic [2*DW-1:0]   m_out,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);
  // Counter must hold MULT_LAT; a zero-latency unit still needs a 1-bit count.
  localparam int CW = (MULT_LAT > 0) ? $clog2(MULT_LAT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [IW-1:0] sel;
  logic          sel_found;
  logic [CW-1:0] cnt;

  // Round-robin search: first valid requester at or above ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel       = IW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept, wait out the multiplier latency, hand back.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sel_found)       state_nxt = S_WAIT;
      S_WAIT:  if (cnt == '0)       state_nxt = S_RESP;
      S_RESP:  if (rsp_ready[gnt])  state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs; req_ready is forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (rst_n && (state == S_IDLE) && sel_found) begin
      req_ready[sel] = 1'b1;
    end
    if (state == S_RESP) begin
      rsp_valid[gnt] = 1'b1;
    end
    busy = (state != S_IDLE);
  end

  // Datapath: operand capture, latency count, product capture, pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      gnt      <= '0;
      cnt      <= '0;
      m_i0     <= '0;
      m_i1     <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            m_i0 <= req_a[sel*DW +: DW];
            m_i1 <= req_b[sel*DW +: DW];
            gnt  <= sel;
            cnt  <= CW'(MULT_LAT);
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            rsp_data <= m_out;
          end
        end
        S_RESP: begin
          // Move past the requester just served so nobody is starved.
          if (rsp_ready[gnt]) begin
            ptr <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arb
// Purpose  : Directed self-checking bench for mult_share_arb with a
//            registered multiplier model attached to m_i0/m_i1/m_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_ready;
  logic [7:0]  m_i0;
  logic [7:0]  m_i1;
  logic [15:0] m_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mult_share_arb #(.NREQ(4), .DW(8), .MULT_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .m_i0      (m_i0),
    .m_i1      (m_i1),
    .m_out     (m_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplier: one registered stage.
  always @(posedge clk) m_out <= 16'(m_i0) * 16'(m_i1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  // One full operation for requester i, assuming rsp_ready[i]=1.
  task automatic expect_op(input int i, input logic [15:0] p);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    check("req_ready", 32'(req_ready), 32'(oh));
    tick();
    check("busy_after_accept", 32'(busy), 32'd1);
    check("req_ready_wait", 32'(req_ready), 32'd0);
    req_valid[i] = 1'b0;
    tick();
    check("rsp_valid_wait", 32'(rsp_valid), 32'd0);
    tick();
    check("rsp_valid", 32'(rsp_valid), 32'(oh));
    check("rsp_data", 32'(rsp_data), 32'(p));
    tick();
    check("busy_done", 32'(busy), 32'd0);
    check("rsp_valid_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 4'b0000;
    #2;
    // Reset state
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_m_i0", 32'(m_i0), 32'd0);
    req_valid = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: req0 3*5, latency 2 cycles after accept
    rsp_ready = 4'b1111;
    set_op(0, 8'd3, 8'd5);
    req_valid = 4'b0001;
    #1;
    check("t1_busy_idle", 32'(busy), 32'd0);
    expect_op(0, 16'd15);
    check("t1_m_i0_hold", 32'(m_i0), 32'd3);
    check("t1_m_i1_hold", 32'(m_i1), 32'd5);

    // 2: req2 255*255 (ptr=1), then req3 0*200 (ptr=3)
    set_op(2, 8'd255, 8'd255);
    req_valid = 4'b0100;
    #1;
    expect_op(2, 16'hFE01);
    set_op(3, 8'd0, 8'd200);
    req_valid = 4'b1000;
    #1;
    expect_op(3, 16'd0);

    // 3: all four valid, ptr=0 -> grants 0,1,2,3 one every 4 cycles
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'(i + 2));
    req_valid = 4'b1111;
    #1;
    expect_op(0, 16'd2);
    expect_op(1, 16'd6);
    expect_op(2, 16'd12);
    expect_op(3, 16'd20);
    // ptr back at 0: with 1 and 3 pending, 1 wins
    req_valid = 4'b1010;
    #1;
    expect_op(1, 16'd6);
    expect_op(3, 16'd20);

    // 4: serve req2 (ptr->3), then req0+req3 -> 3 before 0
    req_valid = 4'b0100;
    #1;
    expect_op(2, 16'd12);
    req_valid = 4'b1001;
    #1;
    expect_op(3, 16'd20);
    expect_op(0, 16'd2);

    // 5: backpressure on req1 response while req0 waits (ptr=1)
    set_op(1, 8'd7, 8'd9);
    set_op(0, 8'd10, 8'd11);
    rsp_ready = 4'b1101;
    req_valid = 4'b0011;
    #1;
    check("t5_req_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    check("t5_rsp_valid", 32'(rsp_valid), 32'b0010);
    check("t5_rsp_data", 32'(rsp_data), 32'd63);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t5_hold_valid", 32'(rsp_valid), 32'b0010);
      check("t5_hold_data", 32'(rsp_data), 32'd63);
      check("t5_hold_ready", 32'(req_ready), 32'd0);
      check("t5_hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 4'b1111;
    tick();
    check("t5_rel_busy", 32'(busy), 32'd0);
    check("t5_rel_rsp_valid", 32'(rsp_valid), 32'd0);
    expect_op(0, 16'd110);

    // 6: reset during WAIT (ptr=1, req2 picked)
    set_op(2, 8'd4, 8'd6);
    req_valid = 4'b0100;
    #1;
    check("t6_req_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1000;
    check("t6_busy_wait", 32'(busy), 32'd1);
    check("t6_m_i0", 32'(m_i0), 32'd4);
    rst_n = 1'b0;
    #1;
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_m_i0_rst", 32'(m_i0), 32'd0);
    check("t6_m_i1_rst", 32'(m_i1), 32'd0);
    check("t6_rsp_data_rst", 32'(rsp_data), 32'd0);
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_req_ready_rst", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_no_rsp", 32'(rsp_valid), 32'd0);
      check("t6_idle", 32'(busy), 32'd0);
    end
    // ptr back at 0: with 1 and 3 pending, 1 wins
    set_op(1, 8'd12, 8'd12);
    set_op(3, 8'd16, 8'd16);
    req_valid = 4'b1010;
    #1;
    expect_op(1, 16'd144);
    expect_op(3, 16'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
Round-robin scheduler that shares one registered multiplier instance (ports clk, i0, i1, output_value) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block sequences one multiply at a time through the shared unit and returns the full-width product to the granted requester on a per-requester response handshake. It sits between the requesting datapath blocks and the single multiplier instance.

Parameters:
NREQ, 4, number of requesters (NREQ >= 2); grant index width is $clog2(NREQ)
DW, 8, operand width; product width is 2*DW
MULT_LAT, 1, cycles from m_i0/m_i1 change to a valid m_out (the shared multiplier registers its output, so 1); 0 is legal for a combinational unit

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_a  in  NREQ*DW  packed operand A; requester i at [i*DW +: DW]
req_b  in  NREQ*DW  packed operand B; same packing
req_ready  out  NREQ  one-hot accept; request accepted on an edge where req_valid[i] & req_ready[i]
rsp_valid  out  NREQ  one-hot response valid to the granted requester
rsp_data  out  2*DW  product, shared by all requesters
rsp_ready  in  NREQ  per-requester response accept
m_i0  out  DW  operand A to the multiplier (registered)
m_i1  out  DW  operand B to the multiplier (registered)
m_out  in  2*DW  multiplier result
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE, ptr 0, grant index 0, cnt 0, m_i0/m_i1 0, rsp_data 0, rsp_valid 0, busy 0. req_ready is 0 while rst_n is low.
- Reset mid-operation drops the in-flight transaction. No response is issued after release.
- FSM states: IDLE, WAIT, RESP. Only one operation is in flight at a time.
- IDLE:
  - req_ready is combinational one-hot. It selects the first set req_valid bit, searching from index ptr upward and wrapping modulo NREQ.
  - req_ready is all zero if no req_valid bit is set.
  - On the accept edge: m_i0 <= req_a[g], m_i1 <= req_b[g], store g, cnt <= MULT_LAT, state <= WAIT.
- WAIT:
  - req_ready is 0.
  - Each edge with cnt != 0: cnt <= cnt - 1.
  - On the edge where cnt == 0: rsp_data <= m_out, state <= RESP.
  - Accept-to-rsp_valid latency is exactly MULT_LAT+1 cycles.
- RESP:
  - rsp_valid[g] = 1, all other bits 0.
  - rsp_data and rsp_valid are held stable until rsp_ready[g] is high on an edge.
  - On that edge: rsp_valid <= 0, ptr <= (g+1) mod NREQ, state <= IDLE.
  - rsp_ready on non-granted indices is ignored.
- Back-to-back: a new request can be accepted in the cycle after response completion. Minimum period is MULT_LAT+3 cycles per operation.
- Fairness: ptr advances past the last served requester, so no requester waits more than NREQ-1 operations once valid.
- Requesters hold req_valid, req_a and req_b stable until accepted. Dropping req_valid before accept is legal and means no grant is given.
- m_i0/m_i1 retain the last operands after completion. rsp_data retains the last product.
- Arithmetic: unsigned, full 2*DW result passed through unmodified, no truncation or saturation.

Test Plan:
1. NREQ=4, DW=8, MULT_LAT=1; req0 a=3 b=5, rsp_ready[0]=1 -> req_ready=4'b0001 in IDLE; rsp_valid=4'b0001 exactly 2 cycles after accept edge; rsp_data=15; busy high from accept until response edge.
2. req2 a=255 b=255 -> rsp_data=16'hFE01 (65025), rsp_valid=4'b0100; operand 0 case a=0 b=200 -> rsp_data=0.
3. All four req_valid high at once, requester i operands (i+1),(i+2), rsp_ready all 1 -> grants in order 0,1,2,3; results 2,6,12,20; one operation every 4 cycles; ptr returns to 0.
4. After serving req2, assert req0 and req3 together -> req3 granted first, then req0.
5. Backpressure: hold rsp_ready[1]=0 for 5 cycles during a req1 response while req0 is valid -> rsp_valid and rsp_data stable; req_ready=0; busy=1; req0 accepted only in the cycle after rsp_ready[1] rises.
6. Drive rst_n low during WAIT -> rsp_valid, m_i0, m_i1, rsp_data and busy go 0 immediately; after release no response appears; next request served starting from ptr 0.
